// File: rtl/mux_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter driving the select of an N:1 valid/ready mux; optional packet hold via `ARB_HOLD_EN`.
// Latency: grant one cycle after a request is seen in IDLE; data/valid/last paths are combinational from the grant.
// Backpressure: out_ready is routed only to the granted requester; the grant is held until release, with no timeout.
module mux_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    // ptr_q doubles as the index of the current grant while in GRANT
    logic [PW-1:0]   ptr_q, ptr_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic            cur_valid;
    logic [W-1:0]    cur_data;
    logic            xfer;
    logic            release_c;

    // Round-robin scan starting just after the last granted index
    always_comb begin
        logic [PW-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!pick_found && in_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the granted requester's valid and data
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q == PW'(i)) begin
                cur_valid = in_valid[i];
                cur_data  = in_data[i*W +: W];
            end
        end
    end

    assign busy      = (state_q == GRANT);
    assign grant     = grant_q;
    assign out_valid = busy & cur_valid;
    assign out_data  = busy ? cur_data : '0;
    // grant_q is zero outside GRANT, so this also gates in_ready while idle
    assign in_ready  = grant_q & {N{out_ready}};
    assign xfer      = out_valid & out_ready;

`ifdef ARB_HOLD_EN
    logic cur_last;
    assign cur_last  = in_last[ptr_q];
    assign out_last  = busy & cur_last;
    // Keep the grant until the end-of-packet beat has moved
    assign release_c = xfer & cur_last;
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign out_last    = 1'b0;
    // Every beat is its own packet
    assign release_c   = xfer;
`endif

    // Next-state: arbitrate in IDLE, wait for release in GRANT
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    ptr_d   = pick_idx;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers; reset points ptr at N-1 so index 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
